// File: rtl/gnr_pkg.sv
// Shared definitions for the Boolean-network attractor search controller:
// FSM state encoding and the default counter width.
package gnr_pkg;

    localparam int GNR_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_STEP   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_PSTEP  = 3'd4,
        ST_PCHECK = 3'd5,
        ST_DONE   = 3'd6
    } gnr_state_e;

endpackage

// File: rtl/gnr_floyd_ctrl.sv
// Floyd tortoise/hare cycle detector that sequences a Boolean network's s0/s1
// tracks to find the attractor reached from a seed, its entry step and its period.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; results from the last search are held
// INIT    | reset_nos loads the latched seed into every node's s0 and s1
// STEP    | strobe both tracks once (hare moves, tortoise every 2nd)
// CHECK   | compare s0/s1 after the step; match, bound or step again
// PSTEP   | hare-only strobe to walk around the attractor
// PCHECK  | compare after the hare-only step; period found, bound or loop
// DONE    | one-cycle done pulse, back to IDLE
module gnr_floyd_ctrl
    import gnr_pkg::*;
#(
    parameter int N_NODES = 4,
    parameter int CNT_W   = GNR_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_NODES-1:0] seed,
    input  logic [CNT_W-1:0]   max_steps,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               reset_nos,
    output logic [N_NODES-1:0] init_state,
    output logic               start_s0,
    output logic               start_s1,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [CNT_W-1:0]   steps,
    output logic [CNT_W-1:0]   period,
    output logic [N_NODES-1:0] attractor
);

    gnr_state_e         r_state;
    gnr_state_e         w_next;

    logic [N_NODES-1:0] r_seed;
    logic [CNT_W-1:0]   r_max;
    logic [CNT_W-1:0]   r_step_cnt;
    logic [CNT_W-1:0]   r_per_cnt;
    logic [CNT_W-1:0]   r_steps;
    logic [CNT_W-1:0]   r_period;
    logic [N_NODES-1:0] r_attr;
    logic               r_timeout;

    logic               w_eq;
    logic               w_step_match;
    logic               w_step_bound;
    logic               w_per_bound;

    assign w_eq         = (s0_vec == s1_vec);
    // The first strobe advances both tracks, so an equality at step 1 is trivial.
    assign w_step_match = w_eq && (r_step_cnt >= CNT_W'(2));
    assign w_step_bound = (r_step_cnt >= r_max);
    assign w_per_bound  = (r_per_cnt >= r_max);

    always_comb begin
        w_next    = r_state;
        reset_nos = 1'b0;
        start_s0  = 1'b0;
        start_s1  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_INIT;
            end
            ST_INIT: begin
                busy      = 1'b1;
                reset_nos = 1'b1;
                w_next    = ST_STEP;
            end
            ST_STEP: begin
                busy     = 1'b1;
                start_s0 = 1'b1;
                start_s1 = 1'b1;
                w_next   = ST_CHECK;
            end
            ST_CHECK: begin
                busy = 1'b1;
                if (w_step_match)      w_next = ST_PSTEP;
                else if (w_step_bound) w_next = ST_DONE;
                else                   w_next = ST_STEP;
            end
            ST_PSTEP: begin
                busy     = 1'b1;
                start_s1 = 1'b1;
                w_next   = ST_PCHECK;
            end
            ST_PCHECK: begin
                busy = 1'b1;
                if (w_eq || w_per_bound) w_next = ST_DONE;
                else                     w_next = ST_PSTEP;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_seed     <= '0;
            r_max      <= '0;
            r_step_cnt <= '0;
            r_per_cnt  <= '0;
            r_steps    <= '0;
            r_period   <= '0;
            r_attr     <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_seed     <= seed;
                        r_max      <= max_steps;
                        r_step_cnt <= '0;
                        r_per_cnt  <= '0;
                        r_steps    <= '0;
                        r_period   <= '0;
                        r_attr     <= '0;
                        r_timeout  <= 1'b0;
                    end
                end
                ST_STEP:  r_step_cnt <= r_step_cnt + CNT_W'(1);
                ST_CHECK: begin
                    if (w_step_match) begin
                        r_steps <= r_step_cnt;
                        r_attr  <= s1_vec;
                    end else if (w_step_bound) begin
                        r_timeout <= 1'b1;
                    end
                end
                ST_PSTEP: r_per_cnt <= r_per_cnt + CNT_W'(1);
                ST_PCHECK: begin
                    if (w_eq)             r_period  <= r_per_cnt;
                    else if (w_per_bound) r_timeout <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign init_state = r_seed;
    assign timeout    = r_timeout;
    assign steps      = r_steps;
    assign period     = r_period;
    assign attractor  = r_attr;

endmodule

// File: tb/tb_gnr_floyd_ctrl.sv
// Bench for gnr_floyd_ctrl: behavioural node arrays drive s0/s1, a scoreboard
// queue holds expected results and a monitor checks them on each done pulse.
module tb_gnr_floyd_ctrl;

    typedef struct packed {
        logic [15:0] steps;
        logic [15:0] period;
        logic [7:0]  attr;
        logic        to;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- DUT A: 4 nodes, f selectable (0: f=0, 1: rotate-left)
    logic        rst_a = 1'b1, start_a = 1'b0, f_sel_a = 1'b0;
    logic [3:0]  seed_a = '0;
    logic [15:0] max_a = '0;
    logic [3:0]  s0_a = '0, s1_a = '0;
    logic        par_a = 1'b0;
    logic        reset_nos_a, start_s0_a, start_s1_a, busy_a, done_a, timeout_a;
    logic [3:0]  init_a, attr_a;
    logic [15:0] steps_a, period_a;

    gnr_floyd_ctrl #(.N_NODES(4), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .seed(seed_a), .max_steps(max_a),
        .s0_vec(s0_a), .s1_vec(s1_a), .reset_nos(reset_nos_a), .init_state(init_a),
        .start_s0(start_s0_a), .start_s1(start_s1_a), .busy(busy_a), .done(done_a),
        .timeout(timeout_a), .steps(steps_a), .period(period_a), .attractor(attr_a)
    );

    // ---------------- DUT B: 8 nodes, rotate-left
    logic        rst_b = 1'b1, start_b = 1'b0;
    logic [7:0]  seed_b = '0;
    logic [15:0] max_b = '0;
    logic [7:0]  s0_b = '0, s1_b = '0;
    logic        par_b = 1'b0;
    logic        reset_nos_b, start_s0_b, start_s1_b, busy_b, done_b, timeout_b;
    logic [7:0]  init_b, attr_b;
    logic [15:0] steps_b, period_b;

    gnr_floyd_ctrl #(.N_NODES(8), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .seed(seed_b), .max_steps(max_b),
        .s0_vec(s0_b), .s1_vec(s1_b), .reset_nos(reset_nos_b), .init_state(init_b),
        .start_s0(start_s0_b), .start_s1(start_s1_b), .busy(busy_b), .done(done_b),
        .timeout(timeout_b), .steps(steps_b), .period(period_b), .attractor(attr_b)
    );

    function automatic logic [3:0] fa(input logic [3:0] x, input logic sel);
        return sel ? {x[2:0], x[3]} : 4'b0000;
    endfunction

    function automatic logic [7:0] fb(input logic [7:0] x);
        return {x[6:0], x[7]};
    endfunction

    // Node models: s1 steps on every start_s1, s0 on odd-numbered start_s0 strobes.
    always @(posedge clk) begin
        if (reset_nos_a) begin
            s0_a <= init_a; s1_a <= init_a; par_a <= 1'b0;
        end else begin
            if (start_s1_a) s1_a <= fa(s1_a, f_sel_a);
            if (start_s0_a) begin
                par_a <= ~par_a;
                if (!par_a) s0_a <= fa(s0_a, f_sel_a);
            end
        end
    end

    always @(posedge clk) begin
        if (reset_nos_b) begin
            s0_b <= init_b; s1_b <= init_b; par_b <= 1'b0;
        end else begin
            if (start_s1_b) s1_b <= fb(s1_b);
            if (start_s0_b) begin
                par_b <= ~par_b;
                if (!par_b) s0_b <= fb(s0_b);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    exp_t q_a[$];
    exp_t q_b[$];
    int   rn_a = 0;
    int   rn_b = 0;

    // Monitor + protocol checker for A
    always @(negedge clk) begin
        exp_t e;
        if (rst_a) rn_a = 0;
        else begin
            if (reset_nos_a) rn_a++;
            chk("a_excl", 32'(reset_nos_a && (start_s0_a || start_s1_a)), 0);
            chk("a_s0_without_s1", 32'(start_s0_a && !start_s1_a), 0);
            chk("a_strobe_idle", 32'(!busy_a && (reset_nos_a || start_s0_a || start_s1_a)), 0);
            chk("a_s0_in_pstep", 32'(start_s0_a && (steps_a != 0)), 0);
            if (done_a) begin
                if (q_a.size() == 0) begin
                    total++; bad++;
                    $display("FAIL a_unexpected_done actual=done required=no_done");
                end else begin
                    e = q_a.pop_front();
                    chk("a_steps", 32'(steps_a), 32'(e.steps));
                    chk("a_period", 32'(period_a), 32'(e.period));
                    chk("a_attractor", 32'(attr_a), 32'(e.attr[3:0]));
                    chk("a_timeout", 32'(timeout_a), 32'(e.to));
                    chk("a_reset_nos_once", rn_a, 1);
                end
                rn_a = 0;
            end
        end
    end

    // Monitor + protocol checker for B
    always @(negedge clk) begin
        exp_t e;
        if (rst_b) rn_b = 0;
        else begin
            if (reset_nos_b) rn_b++;
            chk("b_excl", 32'(reset_nos_b && (start_s0_b || start_s1_b)), 0);
            chk("b_s0_without_s1", 32'(start_s0_b && !start_s1_b), 0);
            chk("b_strobe_idle", 32'(!busy_b && (reset_nos_b || start_s0_b || start_s1_b)), 0);
            chk("b_s0_in_pstep", 32'(start_s0_b && (steps_b != 0)), 0);
            if (done_b) begin
                if (q_b.size() == 0) begin
                    total++; bad++;
                    $display("FAIL b_unexpected_done actual=done required=no_done");
                end else begin
                    e = q_b.pop_front();
                    chk("b_steps", 32'(steps_b), 32'(e.steps));
                    chk("b_period", 32'(period_b), 32'(e.period));
                    chk("b_attractor", 32'(attr_b), 32'(e.attr));
                    chk("b_timeout", 32'(timeout_b), 32'(e.to));
                    chk("b_reset_nos_once", rn_b, 1);
                end
                rn_b = 0;
            end
        end
    end

    task automatic run_a(input logic fsel, input logic [3:0] sd, input logic [15:0] mx,
                         input exp_t e, input bit repulse);
        int cnt;
        f_sel_a = fsel; seed_a = sd; max_a = mx;
        q_a.push_back(e);
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        if (repulse) begin
            seed_a = 4'b1111;
            max_a  = 16'd3;
        end
        cnt = 0;
        while (!done_a && cnt < 500) begin
            @(negedge clk);
            cnt++;
            start_a = repulse && (cnt == 2 || cnt == 5);
        end
        start_a = 1'b0;
        if (!done_a) begin
            total++; bad++;
            $display("FAIL a_done_wait actual=no_done required=done");
        end
        @(negedge clk);
        chk("a_done_one_cycle", 32'(done_a), 0);
    endtask

    task automatic run_b(input logic [7:0] sd, input logic [15:0] mx, input exp_t e);
        int cnt;
        seed_b = sd; max_b = mx;
        q_b.push_back(e);
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        cnt = 0;
        while (!done_b && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        if (!done_b) begin
            total++; bad++;
            $display("FAIL b_done_wait actual=no_done required=done");
        end
        @(negedge clk);
        chk("b_done_one_cycle", 32'(done_b), 0);
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, "_ctl"}, 32'({reset_nos_a, start_s0_a, start_s1_a, busy_a, done_a,
                                timeout_a, init_a, attr_a}), 0);
        chk({tag, "_cnt"}, {steps_a, period_a}, 0);
    endtask

    initial begin
        int n;
        int cnt;
        repeat (3) @(negedge clk);
        chk_zero_a("a_reset");
        chk("b_reset_ctl", 32'({reset_nos_b, start_s0_b, start_s1_b, busy_b, done_b,
                                timeout_b, init_b, attr_b}), 0);
        chk("b_reset_cnt", {steps_b, period_b}, 0);
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (2) @(negedge clk);

        // f=0: both tracks collapse to 0 on the first strobe
        run_a(1'b0, 4'b1010, 16'd20, '{steps: 16'd2, period: 16'd1, attr: 8'h00, to: 1'b0}, 1'b0);
        // rotate-left from 0001: 4-cycle, first Floyd meet at step 8
        run_a(1'b1, 4'b0001, 16'd20, '{steps: 16'd8, period: 16'd4, attr: 8'h01, to: 1'b0}, 1'b0);
        repeat (5) @(negedge clk);
        chk("a_hold_steps", 32'(steps_a), 8);
        chk("a_hold_period", 32'(period_a), 4);
        chk("a_hold_busy", 32'(busy_a), 0);
        // bound of 1 and 0: time out at the first CHECK
        run_a(1'b1, 4'b0001, 16'd1, '{steps: 16'd0, period: 16'd0, attr: 8'h00, to: 1'b1}, 1'b0);
        run_a(1'b1, 4'b0001, 16'd0, '{steps: 16'd0, period: 16'd0, attr: 8'h00, to: 1'b1}, 1'b0);
        // bound of 2 just admits the match at step 2
        run_a(1'b0, 4'b1010, 16'd2, '{steps: 16'd2, period: 16'd1, attr: 8'h00, to: 1'b0}, 1'b0);
        // start re-pulsed mid-search with a different seed/bound must be dropped
        run_a(1'b1, 4'b0001, 16'd20, '{steps: 16'd8, period: 16'd4, attr: 8'h01, to: 1'b0}, 1'b1);
        // 8-node rotate needs step 16 to meet; bound 10 times out
        run_b(8'h01, 16'd10, '{steps: 16'd0, period: 16'd0, attr: 8'h00, to: 1'b1});

        // reset during the third step aborts without a done pulse
        f_sel_a = 1'b1; seed_a = 4'b0001; max_a = 16'd20;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        n = 0; cnt = 0;
        while (n < 3 && cnt < 100) begin
            if (start_s1_a) n++;
            if (n < 3) begin
                @(negedge clk);
                cnt++;
            end
        end
        chk("a_step3_reached", n, 3);
        rst_a = 1'b1;
        @(negedge clk);
        chk_zero_a("a_midrst");
        rst_a = 1'b0;
        repeat (10) @(negedge clk);
        chk("a_post_rst_busy", 32'(busy_a), 0);

        // recovery after the abort
        run_a(1'b0, 4'b1010, 16'd20, '{steps: 16'd2, period: 16'd1, attr: 8'h00, to: 1'b0}, 1'b0);

        repeat (3) @(negedge clk);
        chk("a_queue_empty", q_a.size(), 0);
        chk("b_queue_empty", q_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
